// File: rtl/wb_router_pkg.sv
// Shared types for the Wishbone memory router.
// State and target encodings plus the error read-data fill value.
package wb_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        TGT_CORE = 1'b0,
        TGT_DATA = 1'b1
    } tgt_e;

    // Every bit of the read data returned on a timeout.
    localparam logic ERR_RDATA_BIT = 1'b0;

    localparam int unsigned CTR_WIDTH = 16;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts enabled cycles since the last clear.
// Raises expired on the cycle the count would reach LIMIT.
module wb_timeout_ctr
    import wb_router_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CTR_WIDTH-1:0] LAST = CTR_WIDTH'(LIMIT - 1);

    logic [CTR_WIDTH-1:0] cnt_q;
    logic [CTR_WIDTH-1:0] cnt_d;
    logic                 at_last;

    assign at_last = (cnt_q == LAST);
    assign expired = enable && at_last;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !at_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_mem_router.sv
// Routes one upstream Wishbone request to core memory or data memory.
// Window hits go to m1, everything else to m0; stalls time out with s_err.
module wb_mem_router
    import wb_router_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE      = 'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] DATA_MASK      = 'h8000_0000,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_cyc,
    input  logic                    s_stb,
    input  logic                    s_we,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [ADDR_WIDTH-1:0]   s_adr,
    input  logic [DATA_WIDTH-1:0]   s_dat_w,
    output logic [DATA_WIDTH-1:0]   s_dat_r,
    output logic                    s_ack,
    output logic                    s_err,

    output logic                    m0_cyc,
    output logic                    m0_stb,
    output logic                    m0_we,
    output logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic [ADDR_WIDTH-1:0]   m0_adr,
    output logic [DATA_WIDTH-1:0]   m0_dat_w,
    input  logic [DATA_WIDTH-1:0]   m0_dat_r,
    input  logic                    m0_ack,

    output logic                    m1_cyc,
    output logic                    m1_stb,
    output logic                    m1_we,
    output logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic [ADDR_WIDTH-1:0]   m1_adr,
    output logic [DATA_WIDTH-1:0]   m1_dat_w,
    input  logic [DATA_WIDTH-1:0]   m1_dat_r,
    input  logic                    m1_ack
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    tgt_e                    tgt_q, tgt_d;
    logic                    we_q, we_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic [DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic                    hit;
    logic                    busy;
    logic                    core_sel;
    logic                    data_sel;
    logic                    sel_ack;
    logic [DATA_WIDTH-1:0]   sel_dat_r;
    logic                    tmo_clear;
    logic                    tmo_enable;
    logic                    tmo_expired;

    assign hit       = ((s_adr & DATA_MASK) == DATA_BASE);
    assign busy      = (state_q == BUSY);
    assign core_sel  = (tgt_q == TGT_CORE);
    assign data_sel  = (tgt_q == TGT_DATA);
    assign sel_ack   = data_sel ? m1_ack : m0_ack;
    assign sel_dat_r = data_sel ? m1_dat_r : m0_dat_r;

    assign tmo_clear  = (state_q != BUSY);
    assign tmo_enable = busy && s_cyc && !sel_ack;

    wb_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Transfer sequencing: accept, wait for ack/abort/timeout, respond.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        adr_d   = adr_q;
        dat_w_d = dat_w_q;
        dat_r_d = dat_r_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_cyc && s_stb) begin
                    state_d = BUSY;
                    tgt_d   = hit ? TGT_DATA : TGT_CORE;
                    we_d    = s_we;
                    wstrb_d = s_wstrb;
                    adr_d   = s_adr;
                    dat_w_d = s_dat_w;
                end
            end
            BUSY: begin
                if (!s_cyc) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    state_d = RESP;
                    dat_r_d = sel_dat_r;
                    ack_d   = 1'b1;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                    dat_r_d = {DATA_WIDTH{ERR_RDATA_BIT}};
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= TGT_CORE;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            adr_q   <= '0;
            dat_w_q <= '0;
            dat_r_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            dat_r_q <= dat_r_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign s_dat_r = dat_r_q;
    assign s_ack   = ack_q;
    assign s_err   = err_q;

    // Only the selected port sees the payload; the other stays at zero.
    assign m0_cyc   = busy && core_sel;
    assign m0_stb   = busy && core_sel;
    assign m0_we    = core_sel && we_q;
    assign m0_wstrb = core_sel ? wstrb_q : '0;
    assign m0_adr   = core_sel ? adr_q : '0;
    assign m0_dat_w = core_sel ? dat_w_q : '0;

    assign m1_cyc   = busy && data_sel;
    assign m1_stb   = busy && data_sel;
    assign m1_we    = data_sel && we_q;
    assign m1_wstrb = data_sel ? wstrb_q : '0;
    assign m1_adr   = data_sel ? adr_q : '0;
    assign m1_dat_w = data_sel ? dat_w_q : '0;

endmodule

// File: tb/tb_wb_mem_router.sv
// Directed bench for wb_mem_router with a 4-cycle timeout.
// Each task drives one scenario and checks its own expectations.
module tb_wb_mem_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] s_adr = '0, s_dat_w = '0;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_adr, m0_dat_w;
    logic [31:0] m0_dat_r = '0;
    logic        m0_ack = 1'b0;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_adr, m1_dat_w;
    logic [31:0] m1_dat_r = '0;
    logic        m1_ack = 1'b0;

    int checks = 0;
    int passes = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int m1_seen = 0;
    int both_seen = 0;

    wb_mem_router #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_wstrb  (s_wstrb),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_wstrb (m0_wstrb),
        .m0_adr   (m0_adr),
        .m0_dat_w (m0_dat_w),
        .m0_dat_r (m0_dat_r),
        .m0_ack   (m0_ack),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_wstrb (m1_wstrb),
        .m1_adr   (m1_adr),
        .m1_dat_w (m1_dat_w),
        .m1_dat_r (m1_dat_r),
        .m1_ack   (m1_ack)
    );

    always #5 clk = ~clk;

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (s_ack) ack_cnt++;
        if (s_err) err_cnt++;
        if (m1_cyc) m1_seen++;
        if (s_ack && s_err) both_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        ack_cnt = 0;
        err_cnt = 0;
        m1_seen = 0;
    endtask

    task automatic req(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] strb);
        s_cyc = 1'b1;
        s_stb = 1'b1;
        s_we = we;
        s_adr = adr;
        s_dat_w = dat;
        s_wstrb = strb;
    endtask

    task automatic idle_bus();
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} !== 8'h00)
            $display("FAIL reset_ctrl got %b exp 00000000",
                     {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err});
        else passes++;
        checks++;
        if ({s_dat_r, m0_adr, m1_adr, m0_dat_w, m1_dat_w} !== 160'h0)
            $display("FAIL reset_data got %h exp 0",
                     {s_dat_r, m0_adr, m1_adr, m0_dat_w, m1_dat_w});
        else passes++;
        checks++;
        if ({m0_wstrb, m1_wstrb} !== 8'h00)
            $display("FAIL reset_wstrb got %h exp 00", {m0_wstrb, m1_wstrb});
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_core();
        clr_mon();
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        tick();
        checks++;
        if ({m0_cyc, m0_stb, m0_we, m1_cyc} !== 4'b1100)
            $display("FAIL rd_busy got %b exp 1100", {m0_cyc, m0_stb, m0_we, m1_cyc});
        else passes++;
        checks++;
        if (m0_adr !== 32'h0000_0010)
            $display("FAIL rd_adr got %h exp 00000010", m0_adr);
        else passes++;
        tick();
        m0_ack = 1'b1;
        m0_dat_r = 32'h1234_5678;
        tick();
        m0_ack = 1'b0;
        idle_bus();
        checks++;
        if ({s_ack, s_err, m0_cyc} !== 3'b100)
            $display("FAIL rd_resp got %b exp 100", {s_ack, s_err, m0_cyc});
        else passes++;
        checks++;
        if (s_dat_r !== 32'h1234_5678)
            $display("FAIL rd_data got %h exp 12345678", s_dat_r);
        else passes++;
        tick();
        tick();
        checks++;
        if (ack_cnt !== 1 || m1_seen !== 0)
            $display("FAIL rd_pulses got ack=%0d m1=%0d exp ack=1 m1=0", ack_cnt, m1_seen);
        else passes++;
    endtask

    task automatic test_write_data();
        clr_mon();
        req(1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'b0011);
        tick();
        checks++;
        if ({m1_cyc, m1_stb, m1_we, m0_cyc} !== 4'b1110)
            $display("FAIL wr_busy got %b exp 1110", {m1_cyc, m1_stb, m1_we, m0_cyc});
        else passes++;
        checks++;
        if (m1_adr !== 32'h8000_0004 || m1_dat_w !== 32'hCAFE_F00D || m1_wstrb !== 4'b0011)
            $display("FAIL wr_payload got %h %h %b exp 80000004 cafef00d 0011",
                     m1_adr, m1_dat_w, m1_wstrb);
        else passes++;
        s_adr = 32'h0000_0000;
        s_dat_w = 32'h0;
        s_wstrb = 4'h0;
        tick();
        checks++;
        if (m1_adr !== 32'h8000_0004 || m1_dat_w !== 32'hCAFE_F00D || m1_wstrb !== 4'b0011)
            $display("FAIL wr_stable got %h %h %b exp 80000004 cafef00d 0011",
                     m1_adr, m1_dat_w, m1_wstrb);
        else passes++;
        m1_ack = 1'b1;
        m1_dat_r = 32'h55AA_55AA;
        tick();
        m1_ack = 1'b0;
        idle_bus();
        checks++;
        if ({s_ack, m1_cyc} !== 2'b10 || s_dat_r !== 32'h55AA_55AA)
            $display("FAIL wr_resp got ack=%b cyc=%b dat=%h exp 1 0 55aa55aa",
                     s_ack, m1_cyc, s_dat_r);
        else passes++;
        tick();
        tick();
        checks++;
        if (ack_cnt !== 1)
            $display("FAIL wr_pulses got %0d exp 1", ack_cnt);
        else passes++;
    endtask

    task automatic test_timeout();
        clr_mon();
        req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({m0_cyc, s_err} !== 2'b10)
            $display("FAIL tmo_wait got %b exp 10", {m0_cyc, s_err});
        else passes++;
        tick();
        idle_bus();
        checks++;
        if ({s_err, s_ack, m0_cyc} !== 3'b100)
            $display("FAIL tmo_err got %b exp 100", {s_err, s_ack, m0_cyc});
        else passes++;
        checks++;
        if (s_dat_r !== 32'h0)
            $display("FAIL tmo_data got %h exp 00000000", s_dat_r);
        else passes++;
        tick();
        tick();
        checks++;
        if (err_cnt !== 1 || ack_cnt !== 0 || m0_cyc !== 1'b0)
            $display("FAIL tmo_pulses got err=%0d ack=%0d cyc=%b exp 1 0 0",
                     err_cnt, ack_cnt, m0_cyc);
        else passes++;
    endtask

    task automatic test_ack_at_expiry();
        clr_mon();
        req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        tick();
        m0_ack = 1'b1;
        m0_dat_r = 32'hA5A5_0004;
        tick();
        m0_ack = 1'b0;
        idle_bus();
        checks++;
        if ({s_ack, s_err} !== 2'b10 || s_dat_r !== 32'hA5A5_0004)
            $display("FAIL exp_ack got ack=%b err=%b dat=%h exp 1 0 a5a50004",
                     s_ack, s_err, s_dat_r);
        else passes++;
        tick();
        tick();
        checks++;
        if (err_cnt !== 0 || ack_cnt !== 1)
            $display("FAIL exp_pulses got err=%0d ack=%0d exp 0 1", err_cnt, ack_cnt);
        else passes++;
    endtask

    task automatic test_abort();
        clr_mon();
        req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        tick();
        tick();
        idle_bus();
        tick();
        checks++;
        if (m0_cyc !== 1'b0)
            $display("FAIL abort_drop got %b exp 0", m0_cyc);
        else passes++;
        m0_ack = 1'b1;
        m0_dat_r = 32'hBAD0_BAD0;
        tick();
        m0_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (ack_cnt !== 0 || err_cnt !== 0 || s_dat_r === 32'hBAD0_BAD0)
            $display("FAIL abort_quiet got ack=%0d err=%0d dat=%h exp 0 0 not bad0bad0",
                     ack_cnt, err_cnt, s_dat_r);
        else passes++;
        req(1'b0, 32'h0000_0084, 32'h0, 4'h0);
        tick();
        m0_ack = 1'b1;
        m0_dat_r = 32'h0000_0084;
        tick();
        m0_ack = 1'b0;
        idle_bus();
        checks++;
        if (s_ack !== 1'b1 || s_dat_r !== 32'h0000_0084)
            $display("FAIL abort_recover got ack=%b dat=%h exp 1 00000084", s_ack, s_dat_r);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        clr_mon();
        req(1'b1, 32'h8000_0100, 32'h1111_2222, 4'hF);
        tick();
        checks++;
        if (m1_cyc !== 1'b1)
            $display("FAIL rstmid_busy got %b exp 1", m1_cyc);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({m1_cyc, m1_stb, m1_we, s_ack} !== 4'b0000 || m1_adr !== 32'h0)
            $display("FAIL rstmid_drop got %b adr=%h exp 0000 0",
                     {m1_cyc, m1_stb, m1_we, s_ack}, m1_adr);
        else passes++;
        m1_ack = 1'b1;
        idle_bus();
        tick();
        m1_ack = 1'b0;
        rst = 1'b0;
        tick();
        req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick();
        checks++;
        if ({m0_cyc, m1_cyc} !== 2'b10 || m0_adr !== 32'h0000_0020)
            $display("FAIL rstmid_route got %b adr=%h exp 10 00000020",
                     {m0_cyc, m1_cyc}, m0_adr);
        else passes++;
        m0_ack = 1'b1;
        m0_dat_r = 32'h0000_0020;
        tick();
        m0_ack = 1'b0;
        idle_bus();
        tick();
        tick();
        checks++;
        if (ack_cnt !== 1)
            $display("FAIL rstmid_pulses got %0d exp 1", ack_cnt);
        else passes++;
    endtask

    task automatic test_back_to_back();
        clr_mon();
        req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        tick();
        m1_ack = 1'b1;
        tick();
        m1_ack = 1'b0;
        checks++;
        if ({m0_cyc, s_ack} !== 2'b10)
            $display("FAIL b2b_stray got %b exp 10", {m0_cyc, s_ack});
        else passes++;
        m0_ack = 1'b1;
        m0_dat_r = 32'h0000_0200;
        tick();
        m0_ack = 1'b0;
        req(1'b0, 32'h8000_0300, 32'h0, 4'h0);
        tick();
        checks++;
        if ({m0_cyc, m1_cyc, s_ack} !== 3'b000)
            $display("FAIL b2b_bubble got %b exp 000", {m0_cyc, m1_cyc, s_ack});
        else passes++;
        tick();
        checks++;
        if ({m0_cyc, m1_cyc} !== 2'b01 || m1_adr !== 32'h8000_0300)
            $display("FAIL b2b_second got %b adr=%h exp 01 80000300",
                     {m0_cyc, m1_cyc}, m1_adr);
        else passes++;
        m1_ack = 1'b1;
        m1_dat_r = 32'h0000_0300;
        tick();
        m1_ack = 1'b0;
        idle_bus();
        checks++;
        if (s_ack !== 1'b1 || s_dat_r !== 32'h0000_0300)
            $display("FAIL b2b_resp got ack=%b dat=%h exp 1 00000300", s_ack, s_dat_r);
        else passes++;
        tick();
        tick();
        checks++;
        if (ack_cnt !== 2 || both_seen !== 0)
            $display("FAIL b2b_pulses got ack=%0d both=%0d exp 2 0", ack_cnt, both_seen);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_read_core();
        test_write_data();
        test_timeout();
        test_ack_at_expiry();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
